bsg_tie_monitor: RTL and testbench

- Receiving-end checker for constant tie-off buses: samples a bus that must be tied to a fixed level (all-ones for tie-high nets, all-zeros for tie-low nets) and detects deviations.
- Sits beside tie cells and tie wrappers in test and bring-up builds to flag stuck, shorted or mis-strapped nets.
- Holds a sticky error, an accumulated failing-bit mask and a saturating mismatch-cycle count.
- Reports the first failure of each episode through a valid/yumi handshake.

---
 rtl/bsg_tie_monitor.sv | 156 +++++++++++++++
 tb/tb_bsg_tie_monitor.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_tie_monitor.sv
// bsg_tie_monitor: receive-side checker for a constant tie-off bus.
// It flags any bit that differs from the tied level. The error flag, failing-bit
// mask and saturating mismatch-cycle count are sticky until cleared. The first
// failure of each episode is reported through a valid/yumi handshake.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   eSettle  | post-reset settle window; all samples ignored, clear ignored
//   eMonitor | armed, no report outstanding
//   eReport  | report_v_o high, waiting for report_yumi_i
module bsg_tie_monitor #(
  parameter int width_p         = 16,
  parameter int tie_val_p       = 1,
  parameter int count_width_p   = 8,
  parameter int settle_cycles_p = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [width_p-1:0]       data_i,
  input  logic                     en_i,
  input  logic                     clear_i,
  output logic                     err_o,
  output logic [width_p-1:0]       err_mask_o,
  output logic [count_width_p-1:0] err_count_o,
  output logic                     report_v_o,
  output logic [width_p-1:0]       report_mask_o,
  input  logic                     report_yumi_i
);

  localparam int settle_w_lp = (settle_cycles_p > 0) ? $clog2(settle_cycles_p + 1) : 1;
  localparam logic [settle_w_lp-1:0]   settle_init_lp = settle_w_lp'(settle_cycles_p);
  localparam logic [width_p-1:0]       tie_vec_lp     = (tie_val_p != 0) ? '1 : '0;
  localparam logic [count_width_p-1:0] count_max_lp   = '1;

  typedef enum logic [1:0] {
    eSettle  = 2'd0,
    eMonitor = 2'd1,
    eReport  = 2'd2
  } state_e;

  // With no settle window the monitor is armed straight out of reset.
  localparam state_e init_state_lp = (settle_cycles_p == 0) ? eMonitor : eSettle;

  state_e                   state_q, state_d;
  logic [settle_w_lp-1:0]   settle_q, settle_d;
  logic                     err_q, err_d;
  logic [width_p-1:0]       err_mask_q, err_mask_d;
  logic [count_width_p-1:0] err_count_q, err_count_d;
  logic                     report_v_q, report_v_d;
  logic [width_p-1:0]       report_mask_q, report_mask_d;

  logic [width_p-1:0]       mm;
  logic                     hit;

  // Mismatch vector and hit detect; a disabled sample never mismatches.
  always_comb begin
    mm  = en_i ? (data_i ^ tie_vec_lp) : '0;
    hit = |mm;
  end

  // Next-state and next-output logic for the monitor FSM.
  always_comb begin
    state_d       = state_q;
    settle_d      = settle_q;
    err_d         = err_q;
    err_mask_d    = err_mask_q;
    err_count_d   = err_count_q;
    report_v_d    = report_v_q;
    report_mask_d = report_mask_q;

    // Hit accumulation is shared by eMonitor and eReport; the count holds at
    // its maximum rather than wrapping so a long fault never reads as healthy.
    if ((state_q != eSettle) && !clear_i && hit) begin
      err_d      = 1'b1;
      err_mask_d = err_mask_q | mm;
      if (err_count_q != count_max_lp) begin
        err_count_d = err_count_q + 1'b1;
      end
    end

    unique case (state_q)
      eSettle: begin
        settle_d = settle_q - 1'b1;
        if (settle_q <= settle_w_lp'(1)) begin
          state_d = eMonitor;
        end
      end

      eMonitor: begin
        if (clear_i) begin
          err_d         = 1'b0;
          err_mask_d    = '0;
          err_count_d   = '0;
          report_v_d    = 1'b0;
          report_mask_d = '0;
        end else if (hit) begin
          report_v_d    = 1'b1;
          report_mask_d = mm;
          state_d       = eReport;
        end
      end

      eReport: begin
        // Clear beats yumi. A yumi that coincides with a new hit turns straight
        // into a fresh report, so that failure is not lost.
        if (clear_i) begin
          err_d         = 1'b0;
          err_mask_d    = '0;
          err_count_d   = '0;
          report_v_d    = 1'b0;
          report_mask_d = '0;
          state_d       = eMonitor;
        end else if (report_yumi_i) begin
          if (hit) begin
            report_mask_d = mm;
          end else begin
            report_v_d = 1'b0;
            state_d    = eMonitor;
          end
        end
      end

      default: begin
        state_d = eMonitor;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= init_state_lp;
      settle_q      <= settle_init_lp;
      err_q         <= 1'b0;
      err_mask_q    <= '0;
      err_count_q   <= '0;
      report_v_q    <= 1'b0;
      report_mask_q <= '0;
    end else begin
      state_q       <= state_d;
      settle_q      <= settle_d;
      err_q         <= err_d;
      err_mask_q    <= err_mask_d;
      err_count_q   <= err_count_d;
      report_v_q    <= report_v_d;
      report_mask_q <= report_mask_d;
    end
  end

  assign err_o         = err_q;
  assign err_mask_o    = err_mask_q;
  assign err_count_o   = err_count_q;
  assign report_v_o    = report_v_q;
  assign report_mask_o = report_mask_q;

endmodule

// File: tb/tb_bsg_tie_monitor.sv
// Testbench for bsg_tie_monitor: a tie-high instance (A) and a tie-low instance (B).
module tb_bsg_tie_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset = 1'b1, a_en = 1'b0, a_clear = 1'b0, a_yumi = 1'b0;
  logic [15:0] a_data = 16'hFFFF;
  logic        a_err, a_rv;
  logic [15:0] a_mask, a_rmask;
  logic [7:0]  a_cnt;

  logic        b_reset = 1'b1, b_en = 1'b0, b_clear = 1'b0, b_yumi = 1'b0;
  logic [15:0] b_data = 16'h0000;
  logic        b_err, b_rv;
  logic [15:0] b_mask, b_rmask;
  logic [7:0]  b_cnt;

  int errors = 0;
  int checks = 0;

  bsg_tie_monitor #(.width_p(16), .tie_val_p(1), .count_width_p(8), .settle_cycles_p(4)) dut_a (
    .clk_i(clk), .reset_i(a_reset), .data_i(a_data), .en_i(a_en), .clear_i(a_clear),
    .err_o(a_err), .err_mask_o(a_mask), .err_count_o(a_cnt),
    .report_v_o(a_rv), .report_mask_o(a_rmask), .report_yumi_i(a_yumi));

  bsg_tie_monitor #(.width_p(16), .tie_val_p(0), .count_width_p(8), .settle_cycles_p(4)) dut_b (
    .clk_i(clk), .reset_i(b_reset), .data_i(b_data), .en_i(b_en), .clear_i(b_clear),
    .err_o(b_err), .err_mask_o(b_mask), .err_count_o(b_cnt),
    .report_v_o(b_rv), .report_mask_o(b_rmask), .report_yumi_i(b_yumi));

  // Behavioural reference: what each monitor should have recorded so far.
  logic [15:0] m_tie   [2];
  int          m_settle[2];
  bit          m_err   [2];
  bit          m_pend  [2];
  logic [15:0] m_mask  [2];
  logic [15:0] m_rmask [2];
  int          m_count [2];

  function automatic void model_update(int k, bit rst, bit en, bit clr, bit yumi, logic [15:0] data);
    logic [15:0] mm;
    if (rst) begin
      m_settle[k] = 4; m_err[k] = 0; m_pend[k] = 0;
      m_mask[k] = '0; m_rmask[k] = '0; m_count[k] = 0;
    end else if (m_settle[k] > 0) begin
      m_settle[k] = m_settle[k] - 1;
    end else if (clr) begin
      m_err[k] = 0; m_pend[k] = 0; m_mask[k] = '0; m_rmask[k] = '0; m_count[k] = 0;
    end else begin
      mm = en ? (data ^ m_tie[k]) : 16'h0000;
      if (mm != 16'h0000) begin
        m_err[k]   = 1;
        m_mask[k]  = m_mask[k] | mm;
        m_count[k] = (m_count[k] >= 255) ? 255 : m_count[k] + 1;
        if (!m_pend[k] || yumi) begin
          m_rmask[k] = mm;
          m_pend[k]  = 1;
        end
      end else if (m_pend[k] && yumi) begin
        m_pend[k] = 0;
      end
    end
  endfunction

  // Advance one clock: the reference sees the same inputs as the DUTs, then
  // outputs are sampled 1 time unit after the edge.
  task automatic step();
    model_update(0, a_reset, a_en, a_clear, a_yumi, a_data);
    model_update(1, b_reset, b_en, b_clear, b_yumi, b_data);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_reset = 1; b_reset = 1;
    step(); step();
    checks++;
    if ({a_err, a_mask, a_cnt, a_rv, a_rmask} !== 42'h0) begin
      errors++;
      $display("FAIL reset_a: got err=%b mask=%h cnt=%h v=%b rmask=%h, want all zero",
               a_err, a_mask, a_cnt, a_rv, a_rmask);
    end
    checks++;
    if ({b_err, b_mask, b_cnt, b_rv, b_rmask} !== 42'h0) begin
      errors++;
      $display("FAIL reset_b: got err=%b mask=%h cnt=%h v=%b rmask=%h, want all zero",
               b_err, b_mask, b_cnt, b_rv, b_rmask);
    end
  endtask

  task automatic test_settle();
    a_reset = 0; a_en = 1; a_data = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (a_err !== 1'b0 || a_cnt !== 8'h00) begin
        errors++;
        $display("FAIL settle_ignore[%0d]: got err=%b cnt=%h, want err=0 cnt=00", i, a_err, a_cnt);
      end
    end
    a_data = 16'hFFFF;
    step();
    checks++;
    if (a_err !== 1'b0 || a_cnt !== 8'h00 || a_rv !== 1'b0) begin
      errors++;
      $display("FAIL settle_exit: got err=%b cnt=%h v=%b, want 0 00 0", a_err, a_cnt, a_rv);
    end
  endtask

  task automatic test_single_fault();
    a_data = 16'hFFF7;
    step();
    a_data = 16'hFFFF;
    checks++;
    if ({a_err, a_rv, a_rmask, a_mask, a_cnt} !== {1'b1, 1'b1, 16'h0008, 16'h0008, 8'h01}) begin
      errors++;
      $display("FAIL single_fault: got err=%b v=%b rmask=%h mask=%h cnt=%h, want 1 1 0008 0008 01",
               a_err, a_rv, a_rmask, a_mask, a_cnt);
    end
  endtask

  task automatic test_accumulate();
    a_yumi = 0; a_data = 16'h7FFF;
    step(); step();
    a_data = 16'hFFFF;
    checks++;
    if ({a_mask, a_cnt, a_rmask, a_rv} !== {16'h8008, 8'h03, 16'h0008, 1'b1}) begin
      errors++;
      $display("FAIL accumulate: got mask=%h cnt=%h rmask=%h v=%b, want 8008 03 0008 1",
               a_mask, a_cnt, a_rmask, a_rv);
    end
    a_yumi = 1;
    step();
    a_yumi = 0;
    checks++;
    if (a_rv !== 1'b0 || a_err !== 1'b1 || a_cnt !== 8'h03) begin
      errors++;
      $display("FAIL yumi_ack: got v=%b err=%b cnt=%h, want v=0 err=1 cnt=03", a_rv, a_err, a_cnt);
    end
    // A yumi with nothing pending must change nothing.
    a_yumi = 1;
    step();
    a_yumi = 0;
    checks++;
    if (a_rv !== 1'b0 || a_err !== 1'b1 || a_rmask !== 16'h0008) begin
      errors++;
      $display("FAIL idle_yumi: got v=%b err=%b rmask=%h, want 0 1 0008", a_rv, a_err, a_rmask);
    end
  endtask

  task automatic test_yumi_hit();
    a_data = 16'hFFFD;
    step();
    checks++;
    if (a_rv !== 1'b1 || a_rmask !== 16'h0002) begin
      errors++;
      $display("FAIL new_report: got v=%b rmask=%h, want 1 0002", a_rv, a_rmask);
    end
    a_yumi = 1; a_data = 16'hFFFE;
    step();
    a_yumi = 0; a_data = 16'hFFFF;
    checks++;
    if ({a_rv, a_rmask, a_mask, a_cnt} !== {1'b1, 16'h0001, 16'h800B, 8'h05}) begin
      errors++;
      $display("FAIL yumi_hit: got v=%b rmask=%h mask=%h cnt=%h, want 1 0001 800b 05",
               a_rv, a_rmask, a_mask, a_cnt);
    end
  endtask

  task automatic test_saturate_clear();
    a_data = 16'h0000;
    for (int i = 0; i < 300; i++) step();
    checks++;
    if (a_cnt !== 8'hFF || a_mask !== 16'hFFFF || a_rmask !== 16'h0001) begin
      errors++;
      $display("FAIL saturate: got cnt=%h mask=%h rmask=%h, want ff ffff 0001", a_cnt, a_mask, a_rmask);
    end
    a_clear = 1; a_yumi = 1;
    step();
    a_clear = 0; a_yumi = 0;
    checks++;
    if ({a_err, a_mask, a_cnt, a_rv, a_rmask} !== 42'h0) begin
      errors++;
      $display("FAIL clear: got err=%b mask=%h cnt=%h v=%b rmask=%h, want all zero",
               a_err, a_mask, a_cnt, a_rv, a_rmask);
    end
    a_data = 16'hFFFF;
    step();
    checks++;
    if (a_err !== 1'b0 || a_cnt !== 8'h00 || a_rv !== 1'b0) begin
      errors++;
      $display("FAIL post_clear: got err=%b cnt=%h v=%b, want 0 00 0", a_err, a_cnt, a_rv);
    end
  endtask

  task automatic test_tie_low();
    b_reset = 0; b_en = 1; b_data = 16'h0000;
    for (int i = 0; i < 4; i++) step();
    b_data = 16'h0100; b_en = 0;
    step();
    checks++;
    if (b_err !== 1'b0 || b_rv !== 1'b0 || b_cnt !== 8'h00) begin
      errors++;
      $display("FAIL tie_low_disabled: got err=%b v=%b cnt=%h, want 0 0 00", b_err, b_rv, b_cnt);
    end
    b_en = 1;
    step();
    b_data = 16'h0000;
    checks++;
    if ({b_err, b_rv, b_rmask, b_mask, b_cnt} !== {1'b1, 1'b1, 16'h0100, 16'h0100, 8'h01}) begin
      errors++;
      $display("FAIL tie_low_hit: got err=%b v=%b rmask=%h mask=%h cnt=%h, want 1 1 0100 0100 01",
               b_err, b_rv, b_rmask, b_mask, b_cnt);
    end
    b_reset = 1;
    step();
    b_reset = 0;
    checks++;
    if (b_rv !== 1'b0 || b_err !== 1'b0 || b_rmask !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_report: got v=%b err=%b rmask=%h, want 0 0 0000", b_rv, b_err, b_rmask);
    end
    // The settle window restarts after reset: a wrong value is ignored again.
    b_data = 16'hFFFF;
    step();
    b_data = 16'h0000;
    checks++;
    if (b_err !== 1'b0 || b_cnt !== 8'h00) begin
      errors++;
      $display("FAIL resettle: got err=%b cnt=%h, want 0 00", b_err, b_cnt);
    end
  endtask

  function automatic logic [15:0] rand_data(logic [15:0] tie);
    logic [15:0] d;
    int sel;
    sel = $urandom_range(0, 5);
    if (sel == 0)      d = 16'($urandom);
    else if (sel == 1) d = tie ^ (16'h0001 << $urandom_range(0, 15));
    else               d = tie;
    return d;
  endfunction

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      a_en    = ($urandom_range(0, 3) != 0);
      a_data  = rand_data(16'hFFFF);
      a_clear = ($urandom_range(0, 39) == 0);
      a_yumi  = ($urandom_range(0, 2) == 0);
      a_reset = ($urandom_range(0, 299) == 0);
      b_en    = ($urandom_range(0, 3) != 0);
      b_data  = rand_data(16'h0000);
      b_clear = ($urandom_range(0, 39) == 0);
      b_yumi  = ($urandom_range(0, 2) == 0);
      b_reset = ($urandom_range(0, 299) == 0);
      step();
      checks++;
      if ({a_err, a_mask, a_cnt, a_rv, a_rmask} !==
          {m_err[0], m_mask[0], 8'(m_count[0]), m_pend[0], m_rmask[0]}) begin
        errors++;
        $display("FAIL random_a[%0d]: got err=%b mask=%h cnt=%h v=%b rmask=%h, want err=%b mask=%h cnt=%h v=%b rmask=%h",
                 i, a_err, a_mask, a_cnt, a_rv, a_rmask,
                 m_err[0], m_mask[0], 8'(m_count[0]), m_pend[0], m_rmask[0]);
      end
      checks++;
      if ({b_err, b_mask, b_cnt, b_rv, b_rmask} !==
          {m_err[1], m_mask[1], 8'(m_count[1]), m_pend[1], m_rmask[1]}) begin
        errors++;
        $display("FAIL random_b[%0d]: got err=%b mask=%h cnt=%h v=%b rmask=%h, want err=%b mask=%h cnt=%h v=%b rmask=%h",
                 i, b_err, b_mask, b_cnt, b_rv, b_rmask,
                 m_err[1], m_mask[1], 8'(m_count[1]), m_pend[1], m_rmask[1]);
      end
    end
    a_reset = 0; b_reset = 0; a_clear = 0; b_clear = 0; a_yumi = 0; b_yumi = 0;
  endtask

  initial begin
    m_tie[0] = 16'hFFFF;
    m_tie[1] = 16'h0000;
    for (int k = 0; k < 2; k++) begin
      m_settle[k] = 4; m_err[k] = 0; m_pend[k] = 0;
      m_mask[k] = '0; m_rmask[k] = '0; m_count[k] = 0;
    end
    #2;
    test_reset();
    test_settle();
    test_single_fault();
    test_accumulate();
    test_yumi_hit();
    test_saturate_clear();
    test_tie_low();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
